wait_state_gen: RTL
===================

WAIT_STATE_GEN -- requirements
Module: wait_state_gen

Interface
REQ-001 The module SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock, CPU_CLK rate; all state changes on the rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 ALE  in  1  address latch enable from the CPU; high marks the start of a bus cycle.
REQ-005 RD, WR, INTA  in  1 each  active-low CPU command strobes.
REQ-006 SEL_N  in  4  active-low device-class selects from the address decoder: bit0 ROMRD, bit1 VGA_MEM, bit2 VGA_IO, bit3 slow I/O (IO_TIMER & IO_PIC & IO_DBG).
REQ-007 VGA_BUSY  in  1  high while the video arbiter holds the VGA bus.
REQ-008 CFG_WR  in  1  one-clock write strobe from the chipset port decode (I/O 0x034-0x037).
REQ-009 CFG_ADDR  in  2  configuration register index.
REQ-010 CFG_DATA  in  8  configuration write data.
REQ-011 CFG_Q  out  8  read data of the register selected by CFG_ADDR; combinational.
REQ-012 RDY1  out  1  registered ready to the READY synchroniser; 1 = ready.
REQ-013 TIMEOUT  out  1  sticky VGA-timeout flag.

Function
REQ-014 Registers: index 0 = ROM waits, index 1 = VGA waits, index 2 = slow-I/O waits, each [2:0] with upper bits read 0; index 3 read = {7'b0, TIMEOUT}, and writing 1 to bit0 clears TIMEOUT.
REQ-015 FSM states: IDLE, ARM, COUNT, WAIT_EXT, HOLD.
REQ-016 ALE=1 in any state SHALL move to ARM with RDY1=1, aborting any cycle in progress.
REQ-017 ARM: on the first edge with RD, WR or INTA low, the class SHALL be selected by priority ROM > VGA_MEM > VGA_IO > slow I/O. With no select low, the state SHALL go to HOLD with RDY1=1.
REQ-018 If the selected wait count N > 0, the state SHALL move to COUNT with RDY1=0 at that edge and the counter loaded with N.
REQ-019 COUNT SHALL decrement once per clock. When the counter reaches 1, RDY1=1 at the next edge. RDY1 is therefore low for exactly N clocks.
REQ-020 For VGA classes, COUNT expiry, or N=0, SHALL go to WAIT_EXT instead of releasing RDY1. For non-VGA classes with N=0, the state SHALL go to HOLD with RDY1 never dropping.
REQ-021 WAIT_EXT:
- RDY1=0 while VGA_BUSY=1.
- On VGA_BUSY=0, RDY1=1 at the next edge, then HOLD.
- After 255 consecutive clocks in WAIT_EXT, RDY1=1 is forced, TIMEOUT is set, then HOLD.
REQ-022 HOLD SHALL keep RDY1=1 until RD, WR and INTA are all high, then go to IDLE.
REQ-023 If all strobes go high while in COUNT or WAIT_EXT (early release), the state SHALL go to IDLE with RDY1=1 at the next edge.
REQ-024 A CFG_WR in the same clock as a TIMEOUT set SHALL give priority to the set.
REQ-025 A config write during a cycle SHALL affect only subsequent cycles; the loaded counter is unchanged.

Reset
REQ-026 RESET SHALL immediately force the following, independent of clk:
- state IDLE, RDY1=1, TIMEOUT=0
- counters 0
- ROM waits=2, VGA waits=1, slow-I/O waits=3
REQ-027 Reset asserted mid-cycle SHALL release RDY1 to 1 within the same cycle.

Structure
REQ-028 The state encoding, class encoding, reset wait defaults and timeout limit (255) SHALL live in shared package chipset_pkg.
REQ-029 The config register bank SHALL be a single sub-module, ws_cfg_regs; the FSM and counters stay in wait_state_gen.

Verification
REQ-030 ROM read, defaults after reset: ALE, then RD=0, SEL_N=4'b1110 -> RDY1 low for exactly 2 clocks, then 1 until RD=1.
REQ-031 Slow-I/O write after CFG_WR idx2 data 0x00: ALE, WR=0, SEL_N=4'b0111 -> RDY1 never low.
REQ-032 VGA_MEM read with VGA_BUSY=1 for 5 clocks -> RDY1 low for 1 (count) + 5 clocks, TIMEOUT stays 0.
REQ-033 VGA_IO with VGA_BUSY stuck 1 -> RDY1 released after 255 WAIT_EXT clocks, TIMEOUT=1, CFG_Q idx3 = 0x01; write idx3 0x01 -> TIMEOUT=0.
REQ-034 ROM waits=7, RESET pulse at the 3rd wait clock -> RDY1=1 immediately, ROM waits back to 2.
REQ-035 ROM and VGA_MEM selects both low -> ROM count used, VGA_BUSY ignored.

Source files
------------

// File: rtl/chipset_pkg.sv
// Shared chipset definitions for the wait-state generator.
// Holds the FSM state and device-class encodings, the reset wait-state
// defaults and the WAIT_EXT timeout limit, plus helpers for class priority.
package chipset_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARM      = 3'd1,
      ST_COUNT    = 3'd2,
      ST_WAIT_EXT = 3'd3,
      ST_HOLD     = 3'd4
   } ws_state_t;

   typedef enum logic [1:0] {
      CLS_ROM     = 2'd0,
      CLS_VGA_MEM = 2'd1,
      CLS_VGA_IO  = 2'd2,
      CLS_SLOW_IO = 2'd3
   } ws_class_t;

   localparam logic [2:0] ROM_WAITS_DEF  = 3'd2;
   localparam logic [2:0] VGA_WAITS_DEF  = 3'd1;
   localparam logic [2:0] SLOW_WAITS_DEF = 3'd3;

   // Number of consecutive WAIT_EXT clocks before RDY1 is forced high.
   localparam logic [7:0] WAIT_EXT_LIMIT = 8'd255;

   function automatic logic is_vga_class(input ws_class_t cls);
      return (cls == CLS_VGA_MEM) || (cls == CLS_VGA_IO);
   endfunction

   // Lowest select bit wins: ROM > VGA_MEM > VGA_IO > slow I/O.
   // Caller must separately check that at least one select is low.
   function automatic ws_class_t select_class(input logic [3:0] sel_n);
      if (!sel_n[0])      return CLS_ROM;
      else if (!sel_n[1]) return CLS_VGA_MEM;
      else if (!sel_n[2]) return CLS_VGA_IO;
      else                return CLS_SLOW_IO;
   endfunction

endpackage

// File: rtl/ws_cfg_regs.sv
// Wait-state configuration register bank.
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_cfg_wr             one-clock write strobe
//   i_cfg_addr/i_cfg_data register index and write data
//   i_timeout_set        sets the sticky TIMEOUT flag (wins over a clear)
//   o_cfg_q              combinational read data for i_cfg_addr
//   o_rom_waits/o_vga_waits/o_slow_waits  current wait counts
//   o_timeout            sticky VGA-timeout flag
module ws_cfg_regs
   import chipset_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_cfg_wr,
   input  logic [1:0] i_cfg_addr,
   input  logic [7:0] i_cfg_data,
   input  logic       i_timeout_set,
   output logic [7:0] o_cfg_q,
   output logic [2:0] o_rom_waits,
   output logic [2:0] o_vga_waits,
   output logic [2:0] o_slow_waits,
   output logic       o_timeout
);

   logic [2:0] r_rom_waits;
   logic [2:0] r_vga_waits;
   logic [2:0] r_slow_waits;
   logic       r_timeout;

   // Upper data bits have no storage; they read back as zero.
   logic w_unused_data;
   assign w_unused_data = ^i_cfg_data[7:3];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rom_waits  <= ROM_WAITS_DEF;
         r_vga_waits  <= VGA_WAITS_DEF;
         r_slow_waits <= SLOW_WAITS_DEF;
         r_timeout    <= 1'b0;
      end else begin
         if (i_cfg_wr) begin
            case (i_cfg_addr)
               2'd0:    r_rom_waits  <= i_cfg_data[2:0];
               2'd1:    r_vga_waits  <= i_cfg_data[2:0];
               2'd2:    r_slow_waits <= i_cfg_data[2:0];
               default: ;
            endcase
         end
         // A timeout set in the same clock as a clear must not be lost.
         if (i_timeout_set)
            r_timeout <= 1'b1;
         else if (i_cfg_wr && (i_cfg_addr == 2'd3) && i_cfg_data[0])
            r_timeout <= 1'b0;
      end
   end

   always_comb begin
      o_cfg_q = 8'h00;
      case (i_cfg_addr)
         2'd0:    o_cfg_q = {5'b0, r_rom_waits};
         2'd1:    o_cfg_q = {5'b0, r_vga_waits};
         2'd2:    o_cfg_q = {5'b0, r_slow_waits};
         default: o_cfg_q = {7'b0, r_timeout};
      endcase
   end

   assign o_rom_waits  = r_rom_waits;
   assign o_vga_waits  = r_vga_waits;
   assign o_slow_waits = r_slow_waits;
   assign o_timeout    = r_timeout;

endmodule

// File: rtl/wait_state_gen.sv
// CPU bus wait-state generator.
// Inserts a per-device-class number of wait clocks by holding RDY1 low,
// optionally extended by VGA_BUSY for the VGA classes with a 255-clock
// timeout guard.
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_ale                          address latch enable (starts a bus cycle)
//   i_rd_n, i_wr_n, i_inta_n       active-low command strobes
//   i_sel_n[3:0]                   active-low class selects (ROM, VGA_MEM, VGA_IO, slow I/O)
//   i_vga_busy                     video arbiter owns the VGA bus
//   i_cfg_wr, i_cfg_addr, i_cfg_data  configuration write port
//   o_cfg_q                        configuration read data (combinational)
//   o_rdy1                         registered ready, 1 = ready
//   o_timeout                      sticky VGA-timeout flag
module wait_state_gen
   import chipset_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_ale,
   input  logic       i_rd_n,
   input  logic       i_wr_n,
   input  logic       i_inta_n,
   input  logic [3:0] i_sel_n,
   input  logic       i_vga_busy,
   input  logic       i_cfg_wr,
   input  logic [1:0] i_cfg_addr,
   input  logic [7:0] i_cfg_data,
   output logic [7:0] o_cfg_q,
   output logic       o_rdy1,
   output logic       o_timeout
);

   ws_state_t r_state, w_state_next;
   ws_class_t r_cls, w_cls_next;
   logic [2:0] r_cnt, w_cnt_next;
   logic [7:0] r_wt, w_wt_next;
   logic       r_rdy1, w_rdy_next;
   logic       w_timeout_set;

   logic [2:0] w_rom_waits, w_vga_waits, w_slow_waits;
   logic [2:0] w_sel_waits;
   ws_class_t  w_sel_cls;
   logic       w_sel_valid;
   logic       w_any_strobe;

   ws_cfg_regs u_cfg (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_cfg_wr      (i_cfg_wr),
      .i_cfg_addr    (i_cfg_addr),
      .i_cfg_data    (i_cfg_data),
      .i_timeout_set (w_timeout_set),
      .o_cfg_q       (o_cfg_q),
      .o_rom_waits   (w_rom_waits),
      .o_vga_waits   (w_vga_waits),
      .o_slow_waits  (w_slow_waits),
      .o_timeout     (o_timeout)
   );

   assign w_any_strobe = ~(i_rd_n & i_wr_n & i_inta_n);
   assign w_sel_valid  = ~(&i_sel_n);
   assign w_sel_cls    = select_class(i_sel_n);

   always_comb begin
      w_sel_waits = w_slow_waits;
      case (w_sel_cls)
         CLS_ROM:                 w_sel_waits = w_rom_waits;
         CLS_VGA_MEM, CLS_VGA_IO: w_sel_waits = w_vga_waits;
         default:                 w_sel_waits = w_slow_waits;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_cls   <= CLS_ROM;
         r_cnt   <= 3'd0;
         r_wt    <= 8'd0;
         r_rdy1  <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_cls   <= w_cls_next;
         r_cnt   <= w_cnt_next;
         r_wt    <= w_wt_next;
         r_rdy1  <= w_rdy_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cls_next    = r_cls;
      w_cnt_next    = r_cnt;
      w_wt_next     = r_wt;
      w_rdy_next    = r_rdy1;
      w_timeout_set = 1'b0;

      if (i_ale) begin
         // A new address phase aborts whatever cycle is in progress.
         w_state_next = ST_ARM;
         w_rdy_next   = 1'b1;
         w_cnt_next   = 3'd0;
         w_wt_next    = 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_rdy_next = 1'b1;
            end
            ST_ARM: begin
               w_rdy_next = 1'b1;
               if (w_any_strobe) begin
                  if (!w_sel_valid) begin
                     w_state_next = ST_HOLD;
                  end else begin
                     w_cls_next = w_sel_cls;
                     if (w_sel_waits != 3'd0) begin
                        w_state_next = ST_COUNT;
                        w_cnt_next   = w_sel_waits;
                        w_rdy_next   = 1'b0;
                     end else if (is_vga_class(w_sel_cls)) begin
                        w_state_next = ST_WAIT_EXT;
                        w_wt_next    = 8'd0;
                        w_rdy_next   = 1'b0;
                     end else begin
                        w_state_next = ST_HOLD;
                     end
                  end
               end
            end
            ST_COUNT: begin
               if (!w_any_strobe) begin
                  w_state_next = ST_IDLE;
                  w_rdy_next   = 1'b1;
                  w_cnt_next   = 3'd0;
               end else if (r_cnt == 3'd1) begin
                  w_cnt_next = 3'd0;
                  if (is_vga_class(r_cls)) begin
                     w_state_next = ST_WAIT_EXT;
                     w_wt_next    = 8'd0;
                     w_rdy_next   = 1'b0;
                  end else begin
                     w_state_next = ST_HOLD;
                     w_rdy_next   = 1'b1;
                  end
               end else begin
                  w_cnt_next = r_cnt - 3'd1;
                  w_rdy_next = 1'b0;
               end
            end
            ST_WAIT_EXT: begin
               if (!w_any_strobe) begin
                  w_state_next = ST_IDLE;
                  w_rdy_next   = 1'b1;
                  w_wt_next    = 8'd0;
               end else if (!i_vga_busy) begin
                  w_state_next = ST_HOLD;
                  w_rdy_next   = 1'b1;
                  w_wt_next    = 8'd0;
               end else if (r_wt == WAIT_EXT_LIMIT - 8'd1) begin
                  // r_wt counts completed WAIT_EXT clocks, so this edge is the last allowed.
                  w_state_next  = ST_HOLD;
                  w_rdy_next    = 1'b1;
                  w_wt_next     = 8'd0;
                  w_timeout_set = 1'b1;
               end else begin
                  w_wt_next  = r_wt + 8'd1;
                  w_rdy_next = 1'b0;
               end
            end
            ST_HOLD: begin
               w_rdy_next = 1'b1;
               if (!w_any_strobe) w_state_next = ST_IDLE;
            end
            default: begin
               w_state_next = ST_IDLE;
               w_rdy_next   = 1'b1;
            end
         endcase
      end
   end

   assign o_rdy1 = r_rdy1;

endmodule
